// File: rtl/prio_enc_arb.sv
// Registered priority encoder / round-robin arbiter with valid/ready on both sides.
// Fixed mode picks the highest set bit; round-robin mode searches downward from ptr-1 with wrap.

module prio_hi_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);
  // Ascending scan so the highest set bit is the last assignment to stick.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (vec[k]) begin
        idx = W'(k);
        any = 1'b1;
      end
    end
  end
endmodule

module prio_enc_arb #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         mode_i,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         none,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic         none_q, none_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [N-1:0] lo_mask;
  logic [N-1:0] lo_req;
  logic [W-1:0] lo_idx, all_idx, win_idx;
  logic         lo_any, all_any;
  logic [N-1:0] win_oh;
  logic         accept;

  // Channels strictly below ptr are searched first; if none of them request,
  // the highest request overall is necessarily in ptr..N-1, which completes the wrap.
  for (genvar k = 0; k < N; k++) begin : g_mask
    assign lo_mask[k] = (W'(k) < ptr_q);
  end

  assign lo_req = req_i & lo_mask;

  prio_hi_enc #(.N(N), .W(W)) u_lo_enc (
    .vec (lo_req),
    .idx (lo_idx),
    .any (lo_any)
  );

  prio_hi_enc #(.N(N), .W(W)) u_all_enc (
    .vec (req_i),
    .idx (all_idx),
    .any (all_any)
  );

  assign win_idx = (mode_i && lo_any) ? lo_idx : all_idx;
  assign win_oh  = all_any ? (N'(1) << win_idx) : '0;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    none_d       = none_q;
    ptr_d        = ptr_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_idx_d    = all_any ? win_idx : '0;
      out_onehot_d = win_oh;
      none_d       = !all_any;
      if (mode_i && all_any) ptr_d = win_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      none_q       <= 1'b0;
      ptr_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      none_q       <= none_d;
      ptr_q        <= ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign none       = none_q;

endmodule
